// File: rtl/pipe_ctrl.sv
// Hazard and stall controller for the five-stage core: PC / pipeline-flop hold and flush
// sequencing for load-use, jumps, mul/div waits and bus wait states, plus a stall counter.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_raddr,
    input  logic [4:0]       id_rs2_raddr,
    input  logic             id_rs1_ren,
    input  logic             id_rs2_ren,
    input  logic [4:0]       ex_rd_waddr,
    input  logic             ex_is_load,
    input  logic             jump_en,
    input  logic [31:0]      jump_addr,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_WAIT  = 2'd1,
        ST_BUS_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             md_pend_q, md_pend_d;
    logic             md_done_q, md_done_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic bus_stall;
    logic load_use;
    logic eff_md;
    logic eff_run;

    assign bus_stall = mem_req && !mem_ready;

    assign load_use = ex_is_load && (ex_rd_waddr != REG_AW'(0)) &&
                      ((id_rs1_ren && (id_rs1_raddr == ex_rd_waddr)) ||
                       (id_rs2_ren && (id_rs2_raddr == ex_rd_waddr)));

    // A bus wait that interrupted an unfinished mul/div resumes as MD_WAIT on completion.
    assign eff_md  = (state_q == ST_MD_WAIT) ||
                     ((state_q == ST_BUS_WAIT) && md_pend_q && !md_done_q);
    assign eff_run = (state_q == ST_RUN) ||
                     ((state_q == ST_BUS_WAIT) && !(md_pend_q && !md_done_q));

    // State register, pending/done flags and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            md_pend_q   <= 1'b0;
            md_done_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            md_pend_q <= md_pend_d;
            md_done_q <= md_done_d;
            if (pc_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        md_pend_d = md_pend_q;
        md_done_d = md_done_q;
        if (bus_stall) begin
            state_d = ST_BUS_WAIT;
            unique case (state_q)
                ST_MD_WAIT: begin
                    md_pend_d = !md_done;
                    md_done_d = 1'b0;
                end
                ST_BUS_WAIT: begin
                    if (md_done) begin
                        md_pend_d = 1'b0;
                        md_done_d = 1'b1;
                    end
                end
                default: begin
                    md_pend_d = 1'b0;
                    md_done_d = 1'b0;
                end
            endcase
        end else if (eff_md) begin
            state_d   = md_done ? ST_RUN : ST_MD_WAIT;
            md_pend_d = 1'b0;
            md_done_d = 1'b0;
        end else begin
            // jump_en kills a same-cycle md_start; an unknown state also recovers to RUN here
            state_d   = (md_start && !jump_en && !md_done) ? ST_MD_WAIT : ST_RUN;
            md_pend_d = 1'b0;
            md_done_d = 1'b0;
        end
    end

    // Output logic, priority: bus wait, md wait, jump, load-use
    always_comb begin
        pc_hold    = 1'b0;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_hold  = 1'b0;
        idex_flush = 1'b0;
        exmem_hold = 1'b0;
        jump_en_o  = 1'b0;
        if (!rst) begin
            if (bus_stall) begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_hold  = 1'b1;
                exmem_hold = 1'b1;
            end else if (eff_md || (eff_run && md_start && !jump_en)) begin
                pc_hold   = 1'b1;
                ifid_hold = 1'b1;
                idex_hold = 1'b1;
            end else if (eff_run && jump_en) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                jump_en_o  = 1'b1;
            end else if (eff_run && load_use) begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    assign jump_addr_o = jump_addr;
    assign stall_cnt   = stall_cnt_q;

endmodule
